// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared sizes and the queue entry type for the fetch queue.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int ADDR_W   = 64;
  localparam int INSTR_W  = 32;
  localparam int PC_STEP  = 4;
  localparam int PTR_W    = $clog2(FQ_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo : 4-entry {pc, instr} FIFO with push/pop/clear; empty head reads 0.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fq_entry_t        push_entry,
  output fq_entry_t        head,
  output logic [CNT_W-1:0] count
);

  fq_entry_t        mem_q [FQ_DEPTH];
  fq_entry_t        mem_d [FQ_DEPTH];
  logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
  logic [PTR_W-1:0] tail_ptr_q, tail_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d      = mem_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    // A clear drops everything, including an entry popped in the same cycle.
    if (clear) begin
      head_ptr_d = '0;
      tail_ptr_d = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        mem_d[tail_ptr_q] = push_entry;
        tail_ptr_d        = tail_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        head_ptr_d = head_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      mem_q      <= mem_d;
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head  = (count_q != '0) ? mem_q[head_ptr_q] : '0;
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue : fetch PC register, redirect handling and 4-entry instruction
//               queue. Define FETCH_STATS_EN to add the flush_count port.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        flush_count
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push;
  logic              pop;
  fq_entry_t         push_entry;
  fq_entry_t         head;
  logic [CNT_W-1:0]  count;

  assign pop  = out_valid & out_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign push = !redirect & ((count < CNT_W'(FQ_DEPTH)) | pop);

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_instr;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = align_pc(redirect_pc);
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .clear      (redirect),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign imem_addr = pc_q;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

`ifdef FETCH_STATS_EN
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    flush_count_d = flush_count_q;
    if (redirect && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_count_q <= '0;
    end else begin
      flush_count_q <= flush_count_d;
    end
  end

  assign flush_count = flush_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue : scenario tasks with a pc scoreboard for fetch_queue.
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
`ifdef FETCH_STATS_EN
  logic [15:0] flush_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .flush_count (flush_count)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {a[17:2], 16'hC0DE} ^ a[63:32] ^ 32'h1357_0000;
  endfunction

  always_comb imem_instr = instr_of(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] exp;
    reset = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    reset = 1'b0;
    tick();
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back(64'(4 * i));
    for (int i = 0; i < 4; i++) begin
      exp = sb.pop_front();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL release_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (out_pc !== exp) begin bad++; $display("FAIL release_pc[%0d] got=%h exp=%h", i, out_pc, exp); end
      total++; if (out_instr !== instr_of(exp)) begin bad++; $display("FAIL release_instr[%0d] got=%h exp=%h", i, out_instr, instr_of(exp)); end
      tick();
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    total++; if (imem_addr !== 64'h10) begin bad++; $display("FAIL full_hold_addr got=%h exp=10", imem_addr); end
    total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL full_head_pc got=%h exp=0", out_pc); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", out_valid); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (imem_addr !== 64'h14) begin bad++; $display("FAIL full_pushpop_addr got=%h exp=14", imem_addr); end
    total++; if (out_pc !== 64'h4) begin bad++; $display("FAIL full_pushpop_head got=%h exp=4", out_pc); end
    tick();
    total++; if (imem_addr !== 64'h14) begin bad++; $display("FAIL full_still_full got=%h exp=14", imem_addr); end
  endtask

  task automatic test_flush();
    logic [63:0] exp;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    redirect = 1'b1; redirect_pc = 64'h203;
    tick();
    redirect = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    total++; if (imem_addr !== 64'h200) begin bad++; $display("FAIL flush_addr got=%h exp=200", imem_addr); end
    tick();
    out_ready = 1'b1;
    sb.delete();
    for (int i = 0; i < 6; i++) sb.push_back(64'h200 + 64'(4 * i));
    for (int i = 0; i < 6; i++) begin
      exp = sb.pop_front();
      total++; if (out_pc !== exp || out_valid !== 1'b1) begin bad++; $display("FAIL flush_stream[%0d] got=%h/%b exp=%h/1", i, out_pc, out_valid, exp); end
      tick();
    end
  endtask

  task automatic test_priority();
    out_ready = 1'b1;
    do_reset();
    tick(); tick();
    reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h80;
    tick();
    reset = 1'b0; redirect = 1'b0;
    total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL prio_addr got=%h exp=0", imem_addr); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prio_count got=%b exp=0", out_valid); end
    tick();
    total++; if (out_pc !== 64'h0 || out_valid !== 1'b1) begin bad++; $display("FAIL prio_first got=%h/%b exp=0/1", out_pc, out_valid); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect = 1'b0;
    total++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffffffffffc", imem_addr); end
    tick();
    total++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_pc0 got=%h exp=fffffffffffffffc", out_pc); end
    tick();
    total++; if (out_pc !== 64'h0 || out_valid !== 1'b1) begin bad++; $display("FAIL wrap_pc1 got=%h/%b exp=0/1", out_pc, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int pops = 0;
    out_ready = 1'b0;
    do_reset();
    sb.delete();
    for (int i = 0; i < 80; i++) sb.push_back(64'(4 * i));
    for (int c = 0; c < 80; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      redirect  = (c == 40);
      redirect_pc = 64'h1001;
      if (c == 41) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_post_redirect got=%b exp=0", out_valid); end
      end
      if (out_valid && out_ready) begin
        pops++;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected got=%h exp=none", out_pc);
        end else begin
          exp = sb.pop_front();
          if (out_pc !== exp || out_instr !== instr_of(exp)) begin
            bad++; $display("FAIL b2b_pop got=%h/%h exp=%h/%h", out_pc, out_instr, exp, instr_of(exp));
          end
        end
      end
      if (redirect) begin
        sb.delete();
        for (int i = 0; i < 80; i++) sb.push_back(64'h1000 + 64'(4 * i));
      end
      tick();
    end
    redirect = 1'b0;
    total++; if (pops < 15) begin bad++; $display("FAIL b2b_pop_count got=%0d exp>=15", pops); end
  endtask

  task automatic test_stats();
`ifdef FETCH_STATS_EN
    out_ready = 1'b1;
    do_reset();
    total++; if (flush_count !== 16'd0) begin bad++; $display("FAIL stats_init got=%0d exp=0", flush_count); end
    for (int i = 0; i < 3; i++) begin
      redirect = 1'b1; redirect_pc = 64'h400;
      tick();
      redirect = 1'b0;
      tick();
    end
    total++; if (flush_count !== 16'd3) begin bad++; $display("FAIL stats_three got=%0d exp=3", flush_count); end
    reset = 1'b1; redirect = 1'b1;
    tick();
    reset = 1'b0; redirect = 1'b0;
    total++; if (flush_count !== 16'd0) begin bad++; $display("FAIL stats_reset got=%0d exp=0", flush_count); end
`endif
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_fill();
    test_flush();
    test_priority();
    test_wrap();
    test_back_to_back();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
